// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter feeding several byte requesters into one uart_tx.
// Hands out one byte per frame and tracks the transmitter's ready handshake.
module uart_tx_arbiter #(
    parameter int N_REQ      = 4,
    parameter int DATA_WIDTH = 8
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic [N_REQ-1:0]            req,
    input  logic [N_REQ*DATA_WIDTH-1:0] req_data,
    output logic [N_REQ-1:0]            ack,
    output logic                        tx_start,
    output logic [DATA_WIDTH-1:0]       tx_data,
    input  logic                        tx_ready,
    output logic [$clog2(N_REQ)-1:0]    grant_id,
    output logic                        busy
);

    localparam int GW = $clog2(N_REQ);

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] START     = 2'd1;
    localparam logic [1:0] WAIT_LOW  = 2'd2;
    localparam logic [1:0] WAIT_HIGH = 2'd3;

    logic [1:0]    state;
    logic [1:0]    tmo_cnt;
    logic          found;
    logic [GW-1:0] winner;
    int            idx;

    // Search starts just past the last winner so it gets lowest priority.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        idx    = 0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx = (int'(grant_id) + k) % N_REQ;
            if (!found && req[idx]) begin
                found  = 1'b1;
                winner = GW'(idx);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state    <= IDLE;
            tmo_cnt  <= 2'd0;
            tx_start <= 1'b0;
            ack      <= '0;
            tx_data  <= '0;
            busy     <= 1'b0;
            grant_id <= GW'(N_REQ - 1);
        end else begin
            tx_start <= 1'b0;
            ack      <= '0;
            unique case (state)
                IDLE: begin
                    if (tx_ready && found) begin
                        state    <= START;
                        tx_data  <= req_data[int'(winner)*DATA_WIDTH +: DATA_WIDTH];
                        grant_id <= winner;
                        ack      <= {{(N_REQ-1){1'b0}}, 1'b1} << winner;
                        tx_start <= 1'b1;
                        busy     <= 1'b1;
                    end
                end
                START: begin
                    state   <= WAIT_LOW;
                    tmo_cnt <= 2'd0;
                end
                WAIT_LOW: begin
                    // Give up if the transmitter never acknowledges the start.
                    if (!tx_ready) begin
                        state   <= WAIT_HIGH;
                        tmo_cnt <= 2'd0;
                    end else if (tmo_cnt == 2'd3) begin
                        state   <= IDLE;
                        busy    <= 1'b0;
                        tmo_cnt <= 2'd0;
                    end else begin
                        tmo_cnt <= tmo_cnt + 2'd1;
                    end
                end
                WAIT_HIGH: begin
                    if (tx_ready) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
